// File: rtl/sdram_slave.sv
// Word-addressed SDRAM-style memory slave. It zero-fills itself after reset, then serves
// pipelined reads with a fixed latency. Optional random stalls are enabled by defining SDRAM_SLAVE_STALL_EN.
module sdram_slave #(
  parameter int ADDR_WORDS   = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic        slave_waitrequest,
  output logic [31:0] slave_readdata,
  output logic        slave_readdatavalid,
  output logic        ready,
  output logic        err
);

  localparam int AW = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;

  typedef enum logic {CLEAR, SERVE} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic              wait_q, wait_d;
  logic              ready_q;
  logic              err_q, err_d;
  logic              stall_d;
  logic [31:0]       readdata_q;
  logic [31:0]       mem [ADDR_WORDS];

  logic [29:0]       word_idx;
  logic [AW-1:0]     mem_idx;
  logic              in_range;
  logic              accept, wr_acc, rd_acc;
  logic [31:0]       rd_word;
  logic              unused_addr_lsb;

  assign word_idx        = slave_address[31:2];
  assign mem_idx         = slave_address[AW+1:2];
  assign in_range        = (word_idx < 30'(ADDR_WORDS));
  assign unused_addr_lsb = ^slave_address[1:0];

  // A simultaneous read+write is taken as a write only.
  assign accept  = (state_q == SERVE) && !wait_q && (slave_read || slave_write);
  assign wr_acc  = accept && slave_write;
  assign rd_acc  = accept && slave_read && !slave_write;
  assign rd_word = in_range ? mem[mem_idx] : 32'hDEADBEEF;

`ifdef SDRAM_SLAVE_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // The stall register is loaded from the LFSR value of the coming cycle, so the stall tracks that cycle's lfsr[1:0].
  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == SERVE)
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign stall_d = (lfsr_d[1:0] == 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end
`else
  assign stall_d = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    err_d     = err_q;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q - AW'(1);
        if (clr_ptr_q == '0) state_d = SERVE;
      end
      SERVE: begin
        if (accept && (!in_range || (slave_read && slave_write))) err_d = 1'b1;
      end
      default: state_d = CLEAR;
    endcase
    wait_d = (state_d == SERVE) ? stall_d : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= AW'(ADDR_WORDS - 1);
      wait_q    <= 1'b1;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      wait_q    <= wait_d;
      ready_q   <= (state_d == SERVE);
      err_q     <= err_d;
    end
  end

  // Single write port, shared by the zero-fill and by host writes.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR)
      mem[clr_ptr_q] <= '0;
    else if (wr_acc && in_range)
      mem[mem_idx] <= slave_writedata;
  end

  // ---- read pipeline: stage 0 captures at acceptance, final stage is the output register ----
  logic [READ_LATENCY-1:0] vld_p;
  logic                    last_vld;
  logic [31:0]             last_dat;

  generate
    if (READ_LATENCY == 1) begin : g_direct
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p <= '0;
        else        vld_p <= rd_acc;
      end
      assign last_vld = rd_acc;
      assign last_dat = rd_word;
    end else begin : g_pipe
      logic [31:0] dat_p [READ_LATENCY-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p <= '0;
        else        vld_p <= {vld_p[READ_LATENCY-2:0], rd_acc};
      end

      always_ff @(posedge clk) begin
        dat_p[0] <= rd_word;
        for (int k = 1; k < READ_LATENCY - 1; k++) dat_p[k] <= dat_p[k-1];
      end

      assign last_vld = vld_p[READ_LATENCY-2];
      assign last_dat = dat_p[READ_LATENCY-2];
    end
  endgenerate

  // readdata holds its last value between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        readdata_q <= '0;
    else if (last_vld) readdata_q <= last_dat;
  end

  assign slave_waitrequest   = wait_q;
  assign slave_readdata      = readdata_q;
  assign slave_readdatavalid = vld_p[READ_LATENCY-1];
  assign ready               = ready_q;
  assign err                 = err_q;

endmodule

// File: tb/tb_sdram_slave.sv
// Directed self-checking bench for sdram_slave (ADDR_WORDS=16, READ_LATENCY=2).
module tb_sdram_slave;
  localparam int AWORDS = 16;
  localparam int RLAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] slave_address = '0;
  logic        slave_read = 1'b0;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = '0;
  logic        slave_waitrequest;
  logic [31:0] slave_readdata;
  logic        slave_readdatavalid;
  logic        ready;
  logic        err;

  sdram_slave #(.ADDR_WORDS(AWORDS), .READ_LATENCY(RLAT)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .slave_address       (slave_address),
    .slave_read          (slave_read),
    .slave_write         (slave_write),
    .slave_writedata     (slave_writedata),
    .slave_waitrequest   (slave_waitrequest),
    .slave_readdata      (slave_readdata),
    .slave_readdatavalid (slave_readdatavalid),
    .ready               (ready),
    .err                 (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rsp_data[$];
  int          rsp_cyc[$];
  always @(negedge clk) begin
    if (slave_readdatavalid) begin
      rsp_data.push_back(slave_readdata);
      rsp_cyc.push_back(cyc);
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int acc_cyc = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    int n = 0;
    slave_read = rd; slave_write = wr; slave_address = addr; slave_writedata = data;
    while (slave_waitrequest && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("accept_timeout", {31'd0, slave_waitrequest}, 32'd0);
    acc_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic idle();
    slave_read = 1'b0;
    slave_write = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input string tag);
    int t = 0;
    while (rsp_data.size() < n && t < 50) begin
      @(negedge clk);
      t++;
    end
    check(tag, rsp_data.size(), n);
  endtask

  task automatic flush_rsp();
    rsp_data.delete();
    rsp_cyc.delete();
  endtask

  task automatic wait_clear(input string tag);
    int  n = 0;
    logic stalled = 1'b1;
    while (!ready && n < 100) begin
      if (!slave_waitrequest) stalled = 1'b0;
      @(negedge clk);
      n++;
    end
    check({tag, "_cycles"}, n, AWORDS);
    check({tag, "_wait_held"}, {31'd0, stalled}, 32'd1);
  endtask

  initial begin
    int a0, sz;
    logic [31:0] acc;

    repeat (3) @(negedge clk);
    check("rst_wait",  {31'd0, slave_waitrequest},   32'd1);
    check("rst_ready", {31'd0, ready},               32'd0);
    check("rst_rdv",   {31'd0, slave_readdatavalid}, 32'd0);
    check("rst_rdata", slave_readdata,               32'd0);
    check("rst_err",   {31'd0, err},                 32'd0);

    rst_n = 1'b1;
    wait_clear("clear");

    // zero-filled memory, back-to-back reads
    flush_rsp();
    for (int i = 0; i < AWORDS; i++) begin
      xfer(1'b1, 1'b0, 32'(i * 4), 32'd0);
      if (i == 0) a0 = acc_cyc;
    end
    idle();
    wait_rsp(AWORDS, "zero_rsp_cnt");
    acc = '0;
    foreach (rsp_data[i]) acc |= rsp_data[i];
    check("zero_data", acc, 32'd0);
    check("zero_latency", rsp_cyc[0] - a0, RLAT);

    // write then read next cycle
    flush_rsp();
    xfer(1'b0, 1'b1, 32'h10, 32'h12345678);
    xfer(1'b1, 1'b0, 32'h10, 32'd0);
    a0 = acc_cyc;
    idle();
    wait_rsp(1, "wr_rd_cnt");
    check("wr_rd_data", rsp_data[0], 32'h12345678);
    check("wr_rd_latency", rsp_cyc[0] - a0, RLAT);

    // back-to-back reads of 1,2,3
    flush_rsp();
    xfer(1'b0, 1'b1, 32'h0, 32'd1);
    xfer(1'b0, 1'b1, 32'h4, 32'd2);
    xfer(1'b0, 1'b1, 32'h8, 32'd3);
    xfer(1'b1, 1'b0, 32'h0, 32'd0);
    xfer(1'b1, 1'b0, 32'h4, 32'd0);
    xfer(1'b1, 1'b0, 32'h8, 32'd0);
    idle();
    wait_rsp(3, "b2b_cnt");
    check("b2b_d0", rsp_data[0], 32'd1);
    check("b2b_d1", rsp_data[1], 32'd2);
    check("b2b_d2", rsp_data[2], 32'd3);
`ifndef SDRAM_SLAVE_STALL_EN
    check("b2b_consecutive", rsp_cyc[2] - rsp_cyc[0], 32'd2);
`endif
    check("b2b_err", {31'd0, err}, 32'd0);

    // out of range: 0x40 aliases word 0 in the low index bits
    flush_rsp();
    xfer(1'b1, 1'b0, 32'h40, 32'd0);
    idle();
    wait_rsp(1, "oor_cnt");
    check("oor_data", rsp_data[0], 32'hDEADBEEF);
    check("oor_err", {31'd0, err}, 32'd1);
    xfer(1'b0, 1'b1, 32'h40, 32'hFFFF0000);
    xfer(1'b1, 1'b0, 32'h0, 32'd0);
    idle();
    wait_rsp(2, "oor_wr_cnt");
    check("oor_wr_dropped", rsp_data[1], 32'd1);
    repeat (5) @(negedge clk);
    check("oor_err_sticky", {31'd0, err}, 32'd1);

    // copy 8 words through the master, then verify the destination
    for (int i = 0; i < 8; i++) xfer(1'b0, 1'b1, 32'(i * 4), 32'hC0DE0000 + 32'(i));
    idle();
    for (int i = 0; i < 8; i++) begin
      flush_rsp();
      xfer(1'b1, 1'b0, 32'(i * 4), 32'd0);
      idle();
      wait_rsp(1, "copy_rd_cnt");
      xfer(1'b0, 1'b1, 32'((8 + i) * 4), rsp_data[0]);
      idle();
    end
    flush_rsp();
    for (int i = 0; i < 8; i++) xfer(1'b1, 1'b0, 32'((8 + i) * 4), 32'd0);
    idle();
    wait_rsp(8, "copy_cnt");
    for (int i = 0; i < 8; i++) check($sformatf("copy_w%0d", 8 + i), rsp_data[i], 32'hC0DE0000 + 32'(i));

    // reset while a read is in flight
    flush_rsp();
    xfer(1'b1, 1'b0, 32'h10, 32'd0);
    idle();
    #2 rst_n = 1'b0;
    sz = rsp_data.size();
    @(negedge clk);
    check("midrst_wait", {31'd0, slave_waitrequest}, 32'd1);
    check("midrst_rdata", slave_readdata, 32'd0);
    rst_n = 1'b1;
    check("midrst_err", {31'd0, err}, 32'd0);
    check("midrst_ready", {31'd0, ready}, 32'd0);
    wait_clear("reclear");
    check("midrst_no_stale", rsp_data.size(), sz);
    flush_rsp();
    for (int i = 0; i < AWORDS; i++) xfer(1'b1, 1'b0, 32'(i * 4), 32'd0);
    idle();
    wait_rsp(AWORDS, "reclear_cnt");
    acc = '0;
    foreach (rsp_data[i]) acc |= rsp_data[i];
    check("reclear_data", acc, 32'd0);

    // read and write together: write only, no response, err set
    flush_rsp();
    xfer(1'b1, 1'b1, 32'h0, 32'hA5A5A5A5);
    idle();
    repeat (6) @(negedge clk);
    check("both_no_rsp", rsp_data.size(), 32'd0);
    check("both_err", {31'd0, err}, 32'd1);
    xfer(1'b1, 1'b0, 32'h0, 32'd0);
    idle();
    wait_rsp(1, "both_rd_cnt");
    check("both_data", rsp_data[0], 32'hA5A5A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sdram_slave.md
SDRAM_SLAVE -- requirements
Module: sdram_slave

Interface
REQ-001 SHALL have parameter ADDR_WORDS, default 1024: memory depth in 32-bit words; power of two, 2..65536.
REQ-002 SHALL have parameter READ_LATENCY, default 2: cycles from read acceptance to readdatavalid; legal range 1..8.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port slave_address  input  32  byte address; bits [1:0] ignored.
REQ-006 SHALL have port slave_read  input  1  read request.
REQ-007 SHALL have port slave_write  input  1  write request.
REQ-008 SHALL have port slave_writedata  input  32  write data.
REQ-009 SHALL have port slave_waitrequest  output  1  stall; request not accepted while high.
REQ-010 SHALL have port slave_readdata  output  32  read response data.
REQ-011 SHALL have port slave_readdatavalid  output  1  readdata valid, one-cycle pulse per accepted read.
REQ-012 SHALL have port ready  output  1  memory clear finished.
REQ-013 SHALL have port err  output  1  sticky protocol/range error flag.

Function
REQ-014 SHALL implement states CLEAR and SERVE; CLEAR writes 0 to word ADDR_WORDS-1 down to 0, one word per cycle, then SERVE; SERVE is held until reset.
REQ-015 SHALL hold slave_waitrequest=1 and ready=0 throughout CLEAR; ready=1 from first SERVE cycle.
REQ-016 SHALL accept a request in a cycle where (slave_read|slave_write)=1 and slave_waitrequest=0; requests while waitrequest=1 are ignored and not queued.
REQ-017 SHALL form word index = slave_address[31:2]; address >= 4*ADDR_WORDS is out of range.
REQ-018 SHALL, on accepted in-range write, store slave_writedata at the index on that edge.
REQ-019 SHALL, on accepted read at edge N, drive slave_readdatavalid=1 with data for exactly the cycle after edge N+READ_LATENCY-1 (i.e. READ_LATENCY cycles later); no backpressure.
REQ-020 SHALL sustain one accepted read per cycle, responses in issue order, no gaps inserted.
REQ-021 SHALL return write data to a read accepted the cycle after the write to the same index (write-then-read coherence).
REQ-022 SHALL drop out-of-range writes, return 32'hDEADBEEF for out-of-range reads (with normal latency), and set err.
REQ-023 SHALL treat slave_read and slave_write both high on acceptance as a write only; no read response; set err.
REQ-024 SHALL keep err set until reset; slave_readdata holds last value when readdatavalid=0.
REQ-025 SHALL drive slave_waitrequest, slave_readdatavalid, slave_readdata, ready, err from registers.

Reset
REQ-026 SHALL on rst_n=0 asynchronously force: waitrequest=1, readdatavalid=0, readdata=0, ready=0, err=0, read pipeline flushed, state CLEAR, clear pointer=ADDR_WORDS-1.
REQ-027 SHALL discard in-flight reads on reset mid-operation; no readdatavalid pulse for them after release.
REQ-028 SHALL restart CLEAR on first edge after rst_n deassertion; memory contents after CLEAR are all 0.

Configuration
REQ-029 SHALL, with SDRAM_SLAVE_STALL_EN defined, run a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 at reset, advancing every SERVE cycle) and assert slave_waitrequest in SERVE when lfsr[1:0]==2'b11.
REQ-030 SHALL, without SDRAM_SLAVE_STALL_EN, hold slave_waitrequest=0 in every SERVE cycle and omit the LFSR.

Verification
REQ-031 Reset, ADDR_WORDS=16 -> waitrequest=1, ready=0 for 16 cycles, then ready=1; reads of words 0..15 all return 0.
REQ-032 Write 32'h12345678 @0x10, read @0x10 next cycle, READ_LATENCY=2 -> readdatavalid 2 cycles after read acceptance, readdata=32'h12345678.
REQ-033 Back-to-back reads @0x0,0x4,0x8 after writing 1,2,3 -> three consecutive valid cycles returning 1,2,3; err=0.
REQ-034 Read @0x40 with ADDR_WORDS=16 -> readdata=32'hDEADBEEF, err=1 sticky; write @0x40 leaves memory unchanged.
REQ-035 read=write=1 @0x0 data 32'hA5A5A5A5 -> no readdatavalid, word 0=32'hA5A5A5A5, err=1.
REQ-036 With SDRAM_SLAVE_STALL_EN, copy 8 words via stalling master; rst_n pulsed mid-read -> no stale readdatavalid, CLEAR reruns, memory 0.
